// File: rtl/prio_enc_scan.sv
// Priority-encoding scanner: captures a request vector and emits one set-bit index per beat.
// Latency: first index the cycle after capture, then one index per cycle while dout_ready=1.
// Backpressure: din_ready is low while scanning; dout_ready=0 holds dout, dout_last and pending.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   din_valid/din_ready   request vector handshake, din is N bits wide
//   dout_valid/dout_ready encoded index handshake, dout is W bits wide
//   dout_last             current index is the last set bit of the captured vector
//   zero_seen             one-cycle pulse after an all-zero vector was accepted
//
// Build option: define PRIO_ENC_SCAN_LSB_FIRST_EN to scan lowest set bit first;
// the default build scans highest set bit first.
// W must equal $clog2(N); N may range from 2 to 64.
module prio_enc_scan #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [N-1:0] din,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [W-1:0] dout,
    output logic         dout_last,
    output logic         zero_seen
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_seen_q, zero_seen_d;

    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_mask;
    logic         single_bit;

    // Pick the bit to report. The loop runs towards the preferred end so the
    // last match it sees is the one that wins.
    always_comb begin
        sel_idx  = '0;
        sel_mask = '0;
`ifdef PRIO_ENC_SCAN_LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx  = W'(i);
                sel_mask = ONE << i;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                sel_idx  = W'(i);
                sel_mask = ONE << i;
            end
        end
`endif
    end

    // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
    // pending is never zero while scanning, so this is "exactly one" in SCAN.
    assign single_bit = ((pending_q & (pending_q - ONE)) == '0);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_seen_d = 1'b0;
        din_ready   = 1'b0;
        dout_valid  = 1'b0;
        dout        = '0;
        dout_last   = 1'b0;
        case (state_q)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    if (din != '0) begin
                        pending_d = din;
                        state_d   = SCAN;
                    end else begin
                        zero_seen_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                dout_valid = 1'b1;
                dout       = sel_idx;
                dout_last  = single_bit;
                if (dout_ready) begin
                    pending_d = pending_q & ~sel_mask;
                    if (single_bit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    assign zero_seen = zero_seen_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_seen_q <= zero_seen_d;
        end
    end

endmodule

// File: doc/prio_enc_scan.md
PRIO_ENC_SCAN -- requirements
Module: prio_enc_scan

Interface
REQ-001 Parameter: N, default 8, request vector width; legal range 2..64.
REQ-002 Parameter: W, default 3, index width; SHALL equal ceil(log2(N)); any other value is illegal.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: din_valid  input  1  request vector offered.
REQ-006 Port: din_ready  output  1  block can capture a vector.
REQ-007 Port: din  input  N  request vector, one bit per source.
REQ-008 Port: dout_valid  output  1  encoded index available.
REQ-009 Port: dout_ready  input  1  consumer accepts index.
REQ-010 Port: dout  output  W  encoded bit position of the current set bit.
REQ-011 Port: dout_last  output  1  current index is the final set bit of the captured vector.
REQ-012 Port: zero_seen  output  1  one-cycle pulse: all-zero vector accepted.

Function
REQ-013 Block SHALL have exactly two states: IDLE and SCAN.
REQ-014 IDLE: din_ready=1, dout_valid=0.
REQ-015 IDLE, din_valid=1, din!=0: SHALL capture din into N-bit pending register and enter SCAN at the same edge.
REQ-016 IDLE, din_valid=1, din==0: SHALL consume the vector, stay IDLE, and assert zero_seen for exactly the next cycle; no dout beat.
REQ-017 SCAN: din_ready=0, dout_valid=1; din and din_valid ignored.
REQ-018 SCAN: dout SHALL be the index of the highest set bit of pending (MSB-first order).
REQ-019 SCAN: dout_last=1 iff pending has exactly one bit set.
REQ-020 Beat transfer occurs when dout_valid and dout_ready are both 1; SHALL clear the reported bit in pending at that edge.
REQ-021 Transfer with dout_last=1 SHALL return to IDLE; din_ready=1 the next cycle.
REQ-022 dout_ready=0 in SCAN: dout, dout_last, pending SHALL hold unchanged (no beat lost or repeated).
REQ-023 Latency: capture at edge k, first dout_valid in cycle after edge k; one index per cycle with dout_ready held 1; vector with M set bits occupies exactly M SCAN cycles.
REQ-024 Bit N-1 set alone SHALL encode to N-1 (e.g. N=8: 8'b1000_0000 -> 7); every bit position SHALL map to its own distinct index.
REQ-025 dout, dout_last SHALL be 0 whenever dout_valid=0.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, pending=0, zero_seen=0, regardless of state or handshake.
REQ-027 Reset values: din_ready=1, dout_valid=0, dout=0, dout_last=0, zero_seen=0.
REQ-028 Reset mid-SCAN SHALL discard remaining bits; no beat emitted after reset release until a new vector is captured.
REQ-029 rst_n low SHALL override a simultaneous din or dout handshake.

Configuration
REQ-030 Macro PRIO_ENC_SCAN_LSB_FIRST_EN: when defined, SCAN SHALL report the lowest set bit first (LSB-first order); REQ-018 replaced accordingly.
REQ-031 Macro undefined: MSB-first order per REQ-018; all other requirements identical in both builds.

Verification
REQ-032 N=8, din=8'b1000_0000 accepted, dout_ready=1 -> one beat dout=7, dout_last=1; din_ready=1 next cycle.
REQ-033 N=8, din=8'b1010_0110, dout_ready=1 -> beats 7,5,2,1 on consecutive cycles, dout_last only on 1 (LSB_FIRST build: 1,2,5,7, last on 7).
REQ-034 N=8, din=8'b0000_0000 -> zero_seen one-cycle pulse, no dout_valid, din_ready stays 1.
REQ-035 N=8, din=8'b0011_0000, dout_ready=0 for 3 cycles then 1 -> dout=5 held 4 cycles, then dout=4 with dout_last=1.
REQ-036 N=8, din=8'hFF, rst_n=0 after second beat -> next cycle IDLE, dout_valid=0, din_ready=1, no further beats.
REQ-037 N=16, each one-hot din -> dout equals bit position 0..15, dout_last=1.
